// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: register offsets, interrupt codes,
// reset constants and the bus offset decoder.
package clint_timer_pkg;

    localparam logic [31:0] CLINT_MSIP        = 32'h0000_0000;
    localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
    localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
    localparam logic [31:0] CLINT_MTIME_LO    = 32'h0000_BFF8;
    localparam logic [31:0] CLINT_MTIME_HI    = 32'h0000_BFFC;

    localparam int TIME_INTERRUPT = 7;
    localparam int SOFT_INTERRUPT = 3;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RESP = 1'b1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } reg_sel_t;

    // Misaligned offsets never match an aligned constant, so they fall to NONE.
    function automatic reg_sel_t clint_decode(input logic [31:0] off);
        reg_sel_t sel;
        sel = SEL_NONE;
        if (off == CLINT_MSIP)        sel = SEL_MSIP;
        if (off == CLINT_MTIMECMP_LO) sel = SEL_CMP_LO;
        if (off == CLINT_MTIMECMP_HI) sel = SEL_CMP_HI;
        if (off == CLINT_MTIME_LO)    sel = SEL_TIME_LO;
        if (off == CLINT_MTIME_HI)    sel = SEL_TIME_HI;
        return sel;
    endfunction

endpackage

// File: rtl/clint_timer_prescaler.sv
// Divides the core clock down to the mtime tick.
// tick is high in the cycle the counter sits at TICK_DIV-1.
module clint_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime, mtimecmp and msip on a
// valid/ready bus, plus registered timer/software interrupt levels.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mtime_interrupt,
    output logic              software_interrupt
);

    logic        state_q;
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic        msip_q;

    logic        tick;
    logic        accept;
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    reg_sel_t    sel;

    clint_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign accept     = req_valid && req_ready;
    assign wr         = accept && req_we;
    assign sel        = clint_decode(32'(req_addr));
    assign err        = (sel == SEL_NONE);

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_MSIP:    rdata = {31'd0, msip_q};
            SEL_CMP_LO:  rdata = mtimecmp_q[31:0];
            SEL_CMP_HI:  rdata = mtimecmp_q[63:32];
            SEL_TIME_LO: rdata = mtime_q[31:0];
            SEL_TIME_HI: rdata = mtime_q[63:32];
            default:     rdata = '0;
        endcase
    end

    // A bus write to either mtime half wins over the tick, carry included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= '0;
        end else if (wr && sel == SEL_TIME_LO) begin
            mtime_q[31:0] <= req_wdata;
        end else if (wr && sel == SEL_TIME_HI) begin
            mtime_q[63:32] <= req_wdata;
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
        end else begin
            if (wr && sel == SEL_CMP_LO) mtimecmp_q[31:0]  <= req_wdata;
            if (wr && sel == SEL_CMP_HI) mtimecmp_q[63:32] <= req_wdata;
            if (wr && sel == SEL_MSIP)   msip_q            <= req_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_interrupt    <= 1'b0;
            software_interrupt <= 1'b0;
        end else begin
            mtime_interrupt    <= (mtime_q >= mtimecmp_q);
            software_interrupt <= msip_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q    <= ST_RESP;
                        resp_rdata <= req_we ? 32'd0 : rdata;
                        resp_err   <= err;
                    end
                end
                default: begin
                    if (resp_ready) state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer (TICK_DIV 1 and 4 instances)
// against an arithmetic model of mtime over elapsed clock edges.
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dsel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;

    logic        rr_a, rv_a, re_a, ti_a, si_a;
    logic        rr_b, rv_b, re_b, ti_b, si_b;
    logic [31:0] rd_a, rd_b;

    logic        req_ready, resp_valid, resp_err, tirq, sirq;
    logic [31:0] resp_rdata;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    logic [63:0] m_base;
    int          m_edge;
    logic [63:0] cmp_m;
    logic        msip_m;
    int          tdiv = 1;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    clint_timer #(.ADDR_W(16), .TICK_DIV(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !dsel), .req_ready(rr_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_a), .resp_ready(resp_ready),
        .resp_rdata(rd_a), .resp_err(re_a),
        .mtime_interrupt(ti_a), .software_interrupt(si_a)
    );

    clint_timer #(.ADDR_W(16), .TICK_DIV(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && dsel), .req_ready(rr_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_b), .resp_ready(resp_ready),
        .resp_rdata(rd_b), .resp_err(re_b),
        .mtime_interrupt(ti_b), .software_interrupt(si_b)
    );

    assign req_ready  = dsel ? rr_b : rr_a;
    assign resp_valid = dsel ? rv_b : rv_a;
    assign resp_rdata = dsel ? rd_b : rd_a;
    assign resp_err   = dsel ? re_b : re_a;
    assign tirq       = dsel ? ti_b : ti_a;
    assign sirq       = dsel ? si_b : si_a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mtime after edge b: one increment per edge whose number is a multiple of tdiv
    function automatic logic [63:0] mt_at(input int b);
        return m_base + 64'(b / tdiv) - 64'(m_edge / tdiv);
    endfunction

    function automatic logic [32:0] model_rd(input logic [15:0] a, input int acc);
        logic [63:0] mt;
        mt = mt_at(acc - 1);
        case (a)
            16'h0000: return {1'b0, 31'd0, msip_m};
            16'h4000: return {1'b0, cmp_m[31:0]};
            16'h4004: return {1'b0, cmp_m[63:32]};
            16'hBFF8: return {1'b0, mt[31:0]};
            16'hBFFC: return {1'b0, mt[63:32]};
            default:  return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic model_wr(input logic [15:0] a, input logic [31:0] d, input int acc);
        logic [63:0] old;
        old = mt_at(acc - 1);
        case (a)
            16'h0000: msip_m = d[0];
            16'h4000: cmp_m[31:0] = d;
            16'h4004: cmp_m[63:32] = d;
            16'hBFF8: begin m_base = {old[63:32], d}; m_edge = acc; end
            16'hBFFC: begin m_base = {d, old[31:0]}; m_edge = acc; end
            default: ;
        endcase
    endtask

    task automatic xfer(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input int hold, output logic [31:0] rd, output int acc);
        int n;
        logic [32:0] exp;
        logic er;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        acc = edge_n;
        req_valid = 1'b0;
        exp = model_rd(a, acc);
        if (we) model_wr(a, d, acc);
        check("resp_latency", 64'(resp_valid), 64'd1);
        check("resp_err", 64'(resp_err), 64'(exp[32]));
        check("resp_rdata", 64'(resp_rdata), we ? 64'd0 : 64'(exp[31:0]));
        rd = resp_rdata;
        er = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_rdata", 64'(resp_rdata), 64'(rd));
            check("hold_err", 64'(resp_err), 64'(er));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resp_done", 64'(resp_valid), 64'd0);
    endtask

    task automatic rd_reg(input logic [15:0] a, output logic [31:0] d, output int acc);
        xfer(1'b0, a, 32'd0, 0, d, acc);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int acc;
        xfer(1'b1, a, d, 0, rd, acc);
    endtask

    task automatic do_reset(input logic which);
        mon_en = 1'b0;
        rst_n = 1'b0;
        dsel = which;
        tdiv = which ? 4 : 1;
        m_base = '0; m_edge = 0; cmp_m = '1; msip_m = 1'b0;
        req_valid = 1'b0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_tirq", 64'(tirq), 64'd0);
        check("rst_sirq", 64'(sirq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic random_ops(input int n);
        int op;
        logic [63:0] mt;
        logic [31:0] d;
        int acc;
        for (int i = 0; i < n; i++) begin
            op = int'($urandom_range(0, 8));
            mt = mt_at(edge_n);
            case (op)
                0: rd_reg(16'hBFF8, d, acc);
                1: rd_reg(16'hBFFC, d, acc);
                2: rd_reg(16'h4000, d, acc);
                3: rd_reg(16'h4004, d, acc);
                4: wr_reg(16'h4000, mt[31:0] + 32'($urandom_range(0, 24)));
                5: wr_reg(16'h4004, mt[63:32]);
                6: wr_reg(16'hBFF8, $urandom);
                7: wr_reg(16'h0000, $urandom);
                default: rd_reg(16'($urandom), d, acc);
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    // Interrupt levels follow the state held before each edge
    initial begin
        logic [63:0] p_mt, p_cmp;
        logic p_msip;
        p_mt = '0; p_cmp = '1; p_msip = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                check("mtime_interrupt", 64'(tirq), 64'(p_mt >= p_cmp));
                check("software_interrupt", 64'(sirq), 64'(p_msip));
            end
            p_mt = mt_at(edge_n);
            p_cmp = cmp_m;
            p_msip = msip_m;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, r1, r2;
        logic [31:0] w;
        int k1, k2, a, rise, n;

        do_reset(1'b0);
        rd_reg(16'h4000, d, a);
        check("cmp_lo_rst", 64'(d), 64'hFFFF_FFFF);
        rd_reg(16'h4004, d, a);
        check("cmp_hi_rst", 64'(d), 64'hFFFF_FFFF);
        repeat (100) @(posedge clk);

        wr_reg(16'h4004, 32'd0);
        wr_reg(16'hBFF8, 32'd0);
        wr_reg(16'h4000, 32'd20);
        rise = -1;
        n = 0;
        while (rise < 0 && n < 100) begin
            @(posedge clk);
            #1;
            if (tirq) rise = edge_n;
            n++;
        end
        check("irq_rise_seen", 64'(rise >= 0), 64'd1);
        if (rise >= 0) check("irq_rise_at_20", mt_at(rise - 1), 64'd20);
        wr_reg(16'h4000, 32'hFFFF_FFFF);
        check("irq_fall", 64'(tirq), 64'd0);

        wr_reg(16'hBFF8, 32'hFFFF_FFFE);
        wr_reg(16'hBFFC, 32'h0000_0001);
        repeat (3) @(posedge clk);
        rd_reg(16'hBFFC, d, a);
        check("carry_hi", 64'(d), 64'd2);
        rd_reg(16'hBFF8, d, a);

        wr_reg(16'hBFFC, 32'hFFFF_FFFF);
        wr_reg(16'hBFF8, 32'hFFFF_FFFE);
        repeat (3) @(posedge clk);
        rd_reg(16'hBFFC, d, a);
        check("wrap_hi", 64'(d), 64'd0);
        rd_reg(16'hBFF8, d, a);

        wr_reg(16'h0000, 32'hFFFF_FFFF);
        check("sirq_set", 64'(sirq), 64'd1);
        rd_reg(16'h0000, d, a);
        check("msip_read", 64'(d), 64'd1);
        wr_reg(16'h0000, 32'd0);
        check("sirq_clr", 64'(sirq), 64'd0);

        rd_reg(16'h0010, d, a);
        wr_reg(16'h4002, 32'h1234_5678);
        rd_reg(16'h4000, d, a);
        rd_reg(16'h4004, d, a);
        xfer(1'b0, 16'hBFF8, 32'd0, 5, d, a);

        random_ops(40);

        do_reset(1'b1);
        rd_reg(16'hBFF8, r1, k1);
        repeat (38) @(posedge clk);
        rd_reg(16'hBFF8, r2, k2);
        check("div4_window", 64'(k2 - k1), 64'd40);
        check("div4_advance", 64'(r2 - r1), 64'd10);

        while (((edge_n + 1) % 4) != 0) begin
            @(posedge clk);
            #1;
        end
        w = $urandom;
        xfer(1'b1, 16'hBFF8, w, 0, d, a);
        check("tick_write_edge", 64'(a % 4), 64'd0);
        rd_reg(16'hBFF8, d, a);
        check("tick_write_val", 64'(d), 64'(w));
        rd_reg(16'hBFF8, d, a);
        check("tick_write_hold", 64'(d), 64'(w));
        rd_reg(16'hBFF8, d, a);
        check("tick_write_next", 64'(d), 64'(w + 32'd1));

        random_ops(30);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mon_en = 1'b0;
        check("pre_rst_valid", 64'(resp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
